// File: rtl/led_pkg.sv
// Shared types and helpers for the LED bank scheduler.
// Defines the scheduler state encoding, the default bank width and the
// cyclic round-robin priority search used by the arbiter.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int LED_W_DEF = 10;
  localparam int MAX_REQ   = 8;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } pick_t;

  // Returns the first set bit at or after ptr, wrapping at nreq.
  // Offsets are scanned from high to low so the lowest matching offset is
  // the one that remains assigned.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input int                 nreq,
                                    input logic [2:0]         ptr);
    pick_t res;
    int    idx;
    res = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < nreq) begin
        idx = int'(ptr) + k;
        if (idx >= nreq) idx = idx - nreq;
        if (req[idx[2:0]]) begin
          res.vld = 1'b1;
          res.idx = idx[2:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Purpose: divides clk down to a one-cycle tick every DECIMATION cycles.
// Latency: tick is combinational from the divider count (asserted when count == DECIMATION-1).
// Backpressure: none; the divider free-runs whenever reset is deasserted.
// Ports: clk, reset (async active-low), tick (1-cycle pulse).
module led_tick_gen #(
  parameter logic [19:0] DECIMATION = 20'd16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [19:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == DECIMATION - 20'd1);
    cnt_d = tick ? 20'd0 : cnt_q + 20'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= 20'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_scheduler.sv
// Purpose: time-slices the LED bank between NREQ requesters in round-robin order, heartbeat when idle.
// Latency: all outputs registered, one cycle after the decision cycle.
// Backpressure: none; requesters hold req as a level and an owner dropping req releases its slot early.
// Ports: clk, reset (async active-low); req/pattern/blink per requester (sampled live);
//        grant (one-hot owner), done (slot-expiry pulse), busy (GRANT or GAP), runled (LED drive).
module led_scheduler
  import led_pkg::*;
#(
  parameter int          NREQ       = 4,
  parameter logic [19:0] DECIMATION = 20'd16,
  parameter int          SLOT_TICKS = 8,
  parameter int          LED_W      = LED_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LED_W-1:0]   pattern,
  input  logic [NREQ-1:0]         blink,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [LED_W-1:0]        runled
);

  localparam int                SLOT_W    = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_TICKS - 1);
  localparam logic [2:0]        LAST_IDX  = 3'(NREQ - 1);

  logic tick;

  led_tick_gen #(.DECIMATION(DECIMATION)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  state_e              state_q, state_d;
  logic [2:0]          owner_q, owner_d;
  logic [2:0]          rr_q, rr_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                phase_q, phase_d;
  logic [LED_W-1:0]    hb_q, hb_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic                busy_q, busy_d;
  logic [LED_W-1:0]    runled_q, runled_d;

  // Requester vectors widened to the package's fixed width so a 3-bit
  // owner index always addresses a real bit.
  logic [MAX_REQ-1:0]  req_pad, blink_pad, done_pad, grant_pad;
  logic [LED_W-1:0]    pat_sel;
  pick_t               pick;

  always_comb begin
    req_pad              = '0;
    req_pad[NREQ-1:0]    = req;
    blink_pad            = '0;
    blink_pad[NREQ-1:0]  = blink;
  end

  // Next-state / arbitration
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    slot_d   = slot_q;
    phase_d  = phase_q;
    hb_d     = hb_q;
    done_pad = '0;
    pick     = rr_pick(req_pad, NREQ, rr_q);

    case (state_q)
      IDLE: begin
        if (tick) begin
          hb_d = hb_q + LED_W'(1);
          if (pick.vld) begin
            state_d = GRANT;
            owner_d = pick.idx;
            rr_d    = (pick.idx == LAST_IDX) ? 3'd0 : pick.idx + 3'd1;
            slot_d  = '0;
            phase_d = 1'b1;
          end
        end
      end
      GRANT: begin
        // Owner letting go wins over a simultaneous slot expiry and
        // suppresses done.
        if (!req_pad[owner_q]) begin
          state_d = GAP;
        end else if (tick) begin
          phase_d = ~phase_q;
          if (slot_q == SLOT_LAST) begin
            state_d           = GAP;
            done_pad[owner_q] = 1'b1;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (pick.vld) begin
            state_d = GRANT;
            owner_d = pick.idx;
            rr_d    = (pick.idx == LAST_IDX) ? 3'd0 : pick.idx + 3'd1;
            slot_d  = '0;
            phase_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    grant_pad = '0;
    if (state_d == GRANT) grant_pad = 8'b1 << owner_d;
    grant_d  = grant_pad[NREQ-1:0];
    done_d   = done_pad[NREQ-1:0];
    busy_d   = (state_d != IDLE);
    pat_sel  = pattern[int'(owner_d)*LED_W +: LED_W];
    case (state_d)
      GRANT:   runled_d = (!blink_pad[owner_d] || phase_d) ? pat_sel : '0;
      IDLE:    runled_d = hb_d;
      default: runled_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= 3'd0;
      rr_q     <= 3'd0;
      slot_q   <= '0;
      phase_q  <= 1'b0;
      hb_q     <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      runled_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      slot_q   <= slot_d;
      phase_q  <= phase_d;
      hb_q     <= hb_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      runled_q <= runled_d;
    end
  end

  assign grant  = grant_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign runled = runled_q;

endmodule

// File: tb/tb_led_scheduler.sv
// Scoreboard bench for led_scheduler (NREQ=4, DECIMATION=4, SLOT_TICKS=2).
// The stimulus process steps a behavioural model once per cycle and queues
// the outputs expected after the next clock edge; the monitor pops and compares.
module tb_led_scheduler;

  localparam int NREQ = 4;
  localparam int DEC  = 4;
  localparam int SLOT = 2;
  localparam int LW   = 10;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*LW-1:0] pattern;
  logic [NREQ-1:0]   blink;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [LW-1:0]     runled;

  led_scheduler #(
    .NREQ       (NREQ),
    .DECIMATION (20'd4),
    .SLOT_TICKS (SLOT),
    .LED_W      (LW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .pattern (pattern),
    .blink   (blink),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .runled  (runled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] d;
    logic            b;
    logic [LW-1:0]   led;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic rst_want;

  // Behavioural model: owner < 0 means nobody holds the bank.
  int m_cyc, m_owner, m_hb, m_used, m_rr;
  bit m_gap, m_phase;

  function automatic int pick(input logic [NREQ-1:0] r, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (rr + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_owner = -1; m_hb = 0; m_used = 0; m_rr = 0;
    m_gap = 0; m_phase = 0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ*LW-1:0] p,
                            input logic [NREQ-1:0] b, output exp_t e);
    bit tick;
    int w;
    tick = (m_cyc % DEC) == DEC - 1;
    m_cyc++;
    e = '0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1; m_gap = 1;
      end else if (tick) begin
        if (m_used == SLOT - 1) begin
          e.d[m_owner] = 1'b1; m_owner = -1; m_gap = 1;
        end else begin
          m_used++; m_phase = !m_phase;
        end
      end
    end else if (tick) begin
      if (!m_gap) m_hb = (m_hb + 1) % 1024;
      m_gap = 0;
      w = pick(r, m_rr);
      if (w >= 0) begin
        m_owner = w; m_used = 0; m_phase = 1; m_rr = (w + 1) % NREQ;
      end
    end
    if (m_owner >= 0) begin
      e.g   = NREQ'(1) << m_owner;
      e.b   = 1'b1;
      e.led = (!b[m_owner] || m_phase) ? p[m_owner*LW +: LW] : '0;
    end else if (m_gap) begin
      e.b   = 1'b1;
      e.led = '0;
    end else begin
      e.led = LW'(m_hb);
    end
  endtask

  // One cycle of stimulus: drive at the falling edge, queue the expectation
  // for the following rising edge.
  task automatic drive(input logic [NREQ-1:0] r, input logic [NREQ*LW-1:0] p,
                       input logic [NREQ-1:0] b);
    exp_t e;
    @(negedge clk);
    reset = rst_want; req = r; pattern = p; blink = b;
    if (!rst_want) begin
      model_reset();
      e = '0;
    end else begin
      model_step(r, p, b, e);
    end
    sb_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, want, want);
    end
  endtask

  function automatic logic [NREQ*LW-1:0] rand_pat();
    logic [NREQ*LW-1:0] p;
    for (int i = 0; i < NREQ; i++) p[i*LW +: LW] = LW'($urandom_range(0, 1023));
    return p;
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({grant, done, busy, runled} !== e) begin
          errors++;
          if (errors <= 40)
            $display("FAIL sb_cycle @%0t: got grant=%b done=%b busy=%b runled=%h, want grant=%b done=%b busy=%b runled=%h",
                     $time, grant, done, busy, runled, e.g, e.d, e.b, e.led);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [NREQ*LW-1:0] p;
    logic [NREQ-1:0]    r;
    logic [NREQ-1:0]    b;
    int                 n;

    reset = 1'b0; rst_want = 1'b0;
    req = '0; pattern = '0; blink = '0;
    model_reset();

    // Reset state
    repeat (3) drive('0, '0, '0);
    #1;
    check("reset_grant", int'(grant), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_runled", int'(runled), 0);

    // Heartbeat: 40 cycles after release -> 10 ticks
    rst_want = 1'b1;
    repeat (40) drive('0, '0, '0);
    @(posedge clk); #3;
    check("heartbeat_runled", int'(runled), 10);
    check("heartbeat_grant", int'(grant), 0);
    check("heartbeat_busy", int'(busy), 0);

    // Single request on requester 2, solid pattern
    p = '0; p[2*LW +: LW] = 10'h155;
    repeat (40) drive(4'b0100, p, '0);

    // Round robin with all requesters held
    repeat (80) drive(4'b1111, rand_pat(), '0);

    // Blink on requester 1
    p = rand_pat(); p[1*LW +: LW] = 10'h3FF;
    repeat (30) drive(4'b0010, p, 4'b0010);

    // Early release of requester 0 three cycles into its slot
    repeat (12) drive('0, '0, '0);
    p = rand_pat();
    n = 0;
    while (m_owner != 0 && n < 40) begin
      drive(4'b0001, p, '0);
      n++;
    end
    if (m_owner != 0) check("early_grant_timeout", 0, 1);
    repeat (2) drive(4'b0001, p, '0);
    repeat (30) drive('0, p, '0);

    // Asynchronous reset while a slot is in progress
    n = 0;
    while (m_owner < 0 && n < 20) begin
      drive(4'b1111, rand_pat(), '0);
      n++;
    end
    if (m_owner < 0) check("rst_grant_timeout", 0, 1);
    @(posedge clk); #3;
    check("pre_rst_busy", int'(busy), 1);
    reset = 1'b0; rst_want = 1'b0;
    #1;
    check("async_rst_grant", int'(grant), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_runled", int'(runled), 0);
    repeat (2) drive(4'b1111, '0, '0);
    rst_want = 1'b1;
    p = rand_pat();
    repeat (4) drive(4'b1111, p, '0);
    @(posedge clk); #3;
    check("post_rst_first_grant", int'(grant), 1);
    repeat (20) drive(4'b1111, p, '0);

    // Randomised traffic
    r = '0; b = '0; p = rand_pat();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) r = NREQ'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) b = NREQ'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) p = rand_pat();
      drive(r, p, b);
    end

    // Drain
    repeat (3) drive('0, '0, '0);
    @(posedge clk); #3;
    check("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
